gelu_array_pipe: RTL and testbench

- Parametrised, fully pipelined, multi-lane quantised activation unit for the BERT encoder's FFN non-linear stage.
- Successor to the fixed 32-lane, int8 GELU block. Adds:
  - generic lane count, data width and pipeline depth;
  - a runtime mode select (GELU / ReLU / requantise-only);
  - per-beat scale operands that travel with their data;
  - an elastic valid/ready pipeline with bubble collapse and an occupancy count.
- Sits between the FC1 requantiser and the FC2 input buffer.

---
 rtl/gelu_array_pipe.sv | 144 ++++++++++++++
 tb/tb_gelu_array_pipe.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gelu_array_pipe.sv
// Multi-lane quantised activation (GELU / ReLU / requantise-only) behind an elastic
// valid/ready pipeline. Stage 1 registers the beat, stage 2 the activation, last stage the output.
module gelu_array_pipe #(
  parameter int LANES     = 32,
  parameter int DATA_W    = 8,
  parameter int SCALE_W   = 16,
  parameter int FRAC      = 16,
  parameter int OUT_SHIFT = 16,
  parameter int PIPE      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         data_in_valid,
  output logic                         data_in_ready,
  input  logic [LANES*DATA_W-1:0]      in_data,
  input  logic [SCALE_W-1:0]           in_scale,
  input  logic [SCALE_W-1:0]           out_mult,
  input  logic [1:0]                   mode,
  output logic                         data_out_valid,
  input  logic                         data_out_ready,
  output logic [LANES*DATA_W-1:0]      out_data,
  output logic [$clog2(PIPE+1)-1:0]    occupancy
);

  localparam int OCC_W = $clog2(PIPE + 1);
  localparam int XW    = DATA_W + SCALE_W + 1;
  localparam int PW    = XW + 1;
  localparam int WW    = 2 * XW + FRAC + OUT_SHIFT + 24;

  localparam logic signed [WW-1:0] K436   = WW'(436);
  localparam logic signed [WW-1:0] K10923 = WW'(10923);
  localparam logic signed [WW-1:0] SOff   = WW'(3) <<< FRAC;
  localparam logic signed [WW-1:0] SMax   = WW'(6) <<< FRAC;
  localparam logic signed [WW-1:0] Rnd    = WW'(1) <<< (FRAC + OUT_SHIFT - 1);
  localparam logic signed [WW-1:0] QMax   = (WW'(1) <<< (DATA_W - 1)) - WW'(1);
  localparam logic signed [WW-1:0] QMin   = -(WW'(1) <<< (DATA_W - 1));

  // Dequantise and apply the selected activation; result in Q.FRAC.
  function automatic logic signed [PW-1:0] act_fn(input logic signed [DATA_W-1:0] din,
                                                   input logic [SCALE_W-1:0]      sc,
                                                   input logic [1:0]              md);
    logic signed [WW-1:0] xd, xs, x, t, s, p;
    xd = WW'(din);
    xs = WW'({1'b0, sc});
    x  = xd * xs;
    t  = (x * K436) >>> 8;
    s  = t + SOff;
    if (s[WW-1]) s = '0;
    else if (s > SMax) s = SMax;
    case (md)
      2'd0:    p = (((x * s) >>> FRAC) * K10923) >>> 16;
      2'd1:    p = x[WW-1] ? '0 : x;
      default: p = x;
    endcase
    return PW'(p);
  endfunction

  // Requantise with round-half-up, then saturate to the lane width.
  function automatic logic [DATA_W-1:0] rq_fn(input logic signed [PW-1:0] p,
                                              input logic [SCALE_W-1:0]  om);
    logic signed [WW-1:0] pe, me, q;
    pe = WW'(p);
    me = WW'({1'b0, om});
    q  = (pe * me + Rnd) >>> (FRAC + OUT_SHIFT);
    if (q > QMax) q = QMax;
    else if (q < QMin) q = QMin;
    return DATA_W'(q);
  endfunction

  logic [PIPE:1]             v_q;
  logic [PIPE:1]             vin;
  logic [PIPE:1]             rdy;
  logic [OCC_W-1:0]          occ_q;
  logic                      accept, emit;

  logic [LANES*DATA_W-1:0]   d1_q;
  logic [SCALE_W-1:0]        sc1_q;
  logic [SCALE_W-1:0]        om1_q;
  logic [1:0]                md1_q;
  logic signed [PW-1:0]      p_q [2:PIPE-1][LANES];
  logic [SCALE_W-1:0]        om_q [2:PIPE-1];
  logic signed [PW-1:0]      p_next [LANES];
  logic [LANES*DATA_W-1:0]   out_next;

  assign vin = {v_q[PIPE-1:1], data_in_valid};

  // A stage may load when empty or when its content moves on this cycle.
  always_comb begin
    rdy       = '0;
    rdy[PIPE] = !v_q[PIPE] || data_out_ready;
    for (int k = PIPE - 1; k >= 1; k--) begin
      rdy[k] = !v_q[k] || rdy[k+1];
    end
  end

  assign data_in_ready  = rdy[1];
  assign data_out_valid = v_q[PIPE];
  assign occupancy      = occ_q;
  assign accept         = data_in_valid && rdy[1];
  assign emit           = v_q[PIPE] && data_out_ready;

  always_comb begin
    out_next = '0;
    for (int i = 0; i < LANES; i++) begin
      p_next[i] = act_fn($signed(d1_q[i*DATA_W +: DATA_W]), sc1_q, md1_q);
      out_next[i*DATA_W +: DATA_W] = rq_fn(p_q[PIPE-1][i], om_q[PIPE-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q      <= '0;
      occ_q    <= '0;
      out_data <= '0;
    end else begin
      for (int k = 1; k <= PIPE; k++) begin
        if (rdy[k]) v_q[k] <= vin[k];
      end
      occ_q <= occ_q + OCC_W'(accept) - OCC_W'(emit);
      if (vin[PIPE] && rdy[PIPE]) out_data <= out_next;
    end
  end

  // Payload registers load only with a valid beat, so a stalled stage holds its data.
  always_ff @(posedge clk) begin
    if (vin[1] && rdy[1]) begin
      d1_q  <= in_data;
      sc1_q <= in_scale;
      om1_q <= out_mult;
      md1_q <= mode;
    end
    if (vin[2] && rdy[2]) begin
      p_q[2]  <= p_next;
      om_q[2] <= om1_q;
    end
    for (int k = 3; k <= PIPE - 1; k++) begin
      if (vin[k] && rdy[k]) begin
        p_q[k]  <= p_q[k-1];
        om_q[k] <= om_q[k-1];
      end
    end
  end

endmodule

// File: tb/tb_gelu_array_pipe.sv
// Scoreboard bench for gelu_array_pipe: expected beats queued at drive time, checked on emit.
module tb_gelu_array_pipe;
  localparam int LANES = 32;
  localparam int DW    = 8;
  localparam int SW    = 20;
  localparam int PIPE  = 4;
  localparam int VW    = LANES * DW;

  logic               clk = 1'b0;
  logic               rst;
  logic               data_in_valid, data_in_ready;
  logic [VW-1:0]      in_data;
  logic [SW-1:0]      in_scale, out_mult;
  logic [1:0]         mode;
  logic               data_out_valid, data_out_ready;
  logic [VW-1:0]      out_data;
  logic [2:0]         occupancy;

  gelu_array_pipe #(
    .LANES(LANES), .DATA_W(DW), .SCALE_W(SW), .FRAC(16), .OUT_SHIFT(16), .PIPE(PIPE)
  ) dut (
    .clk(clk), .rst(rst), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .in_data(in_data), .in_scale(in_scale), .out_mult(out_mult), .mode(mode),
    .data_out_valid(data_out_valid), .data_out_ready(data_out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            checks = 0;
  int            errors = 0;
  logic [VW-1:0] exp_q[$];
  int            inflight = 0;
  int            max_occ = 0;
  logic          prev_stall = 1'b0;
  logic [VW-1:0] prev_data;

  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] lanes5(input int a, input int b, input int c, input int d,
                                           input int e);
    logic [VW-1:0] v;
    v = '0;
    v[7:0] = 8'(a); v[15:8] = 8'(b); v[23:16] = 8'(c); v[31:24] = 8'(d); v[39:32] = 8'(e);
    return v;
  endfunction

  function automatic logic [7:0] ref_lane(input int din, input longint sc, input longint om,
                                          input int md);
    longint x, t, s, p, q;
    x = longint'(din) * sc;
    if (md == 0) begin
      t = (x * 436) >>> 8;
      s = t + (64'sd3 <<< 16);
      if (s < 0) s = 0;
      else if (s > (64'sd6 <<< 16)) s = 64'sd6 <<< 16;
      p = (((x * s) >>> 16) * 10923) >>> 16;
    end else if (md == 1) begin
      p = (x < 0) ? 0 : x;
    end else begin
      p = x;
    end
    q = (p * om + (64'sd1 <<< 31)) >>> 32;
    if (q > 127) q = 127;
    else if (q < -128) q = -128;
    return 8'(q);
  endfunction

  function automatic logic [VW-1:0] ref_vec(input logic [VW-1:0] d, input int sc, input int om,
                                            input int md);
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) begin
      v[i*DW +: DW] = ref_lane(int'($signed(d[i*DW +: DW])), longint'(sc), longint'(om), md);
    end
    return v;
  endfunction

  // Monitor: occupancy tracking, full/stall rules and in-order scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      inflight   = 0;
      prev_stall = 1'b0;
    end else begin
      chk("occupancy", occupancy, inflight);
      if (occupancy == PIPE && !data_out_ready) chk("ready_when_full", data_in_ready, 0);
      if (int'(occupancy) > max_occ) max_occ = occupancy;
      if (prev_stall) chk("stall_hold", out_data, prev_data);
      if (data_out_valid && data_out_ready) begin
        chk("out_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("out_data", out_data, exp_q.pop_front());
      end
      inflight += int'(data_in_valid && data_in_ready) - int'(data_out_valid && data_out_ready);
      prev_stall = data_out_valid && !data_out_ready;
      prev_data  = out_data;
    end
  end

  task automatic send(input logic [VW-1:0] d, input int sc, input int om, input int md,
                      input logic [VW-1:0] exp);
    int n;
    @(posedge clk); #1;
    in_data       = d;
    in_scale      = SW'(sc);
    out_mult      = SW'(om);
    mode          = 2'(md);
    data_in_valid = 1'b1;
    exp_q.push_back(exp);
    n = 0;
    @(negedge clk);
    while (!data_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!data_in_ready) chk("in_ready_timeout", data_in_ready, 1);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    data_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int            a, n;
    logic [VW-1:0] d;
    int            sc, om, md;

    rst = 1'b1; data_in_valid = 1'b0; data_out_ready = 1'b1;
    in_data = '0; in_scale = '0; out_mult = '0; mode = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", data_out_valid, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_in_ready", data_in_ready, 1);
    chk("rst_out_data", out_data, 0);

    // Basic GELU and latency
    send(lanes5(3, -3, 1, -1, 0), 65536, 65536, 0, lanes5(3, 0, 1, 0, 0));
    a = cyc;
    idle();
    n = 0;
    while (!data_out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", cyc - a, PIPE);
    drain();

    // Saturation and modes
    send(lanes5(127, -128, 0, 0, 0), 65536, 262144, 0, lanes5(127, 0, 0, 0, 0));
    send(lanes5(-5, 0, 0, 0, 0), 65536, 65536, 1, lanes5(0, 0, 0, 0, 0));
    send(lanes5(-5, 0, 0, 0, 0), 65536, 65536, 2, lanes5(-5, 0, 0, 0, 0));
    send(lanes5(-5, 0, 0, 0, 0), 65536, 65536, 3, lanes5(-5, 0, 0, 0, 0));
    send(lanes5(100, 0, 0, 0, 0), 65536, 163840, 2, lanes5(127, 0, 0, 0, 0));
    idle();
    drain();

    // Sideband travels with each beat
    send(lanes5(-1, 0, 0, 0, 0), 65536, 65536, 0, lanes5(0, 0, 0, 0, 0));
    send(lanes5(-1, 0, 0, 0, 0), 65536, 65536, 1, lanes5(0, 0, 0, 0, 0));
    send(lanes5(-1, 0, 0, 0, 0), 65536, 65536, 0, lanes5(0, 0, 0, 0, 0));
    send(lanes5(1, 0, 0, 0, 0), 65536, 65536, 0, lanes5(1, 0, 0, 0, 0));
    send(lanes5(1, 0, 0, 0, 0), 131072, 65536, 0, lanes5(2, 0, 0, 0, 0));
    idle();
    drain();

    // Backpressure
    max_occ = 0;
    fork
      begin
        for (int i = 1; i <= 10; i++) send(lanes5(i, 0, 0, 0, 0), 65536, 65536, 2, lanes5(i, 0, 0, 0, 0));
        idle();
      end
      begin
        repeat (3) @(posedge clk);
        #1 data_out_ready = 1'b0;
        repeat (7) @(posedge clk);
        #1 data_out_ready = 1'b1;
      end
    join
    drain();
    chk("max_occupancy", max_occ, PIPE);

    // Random lanes against the arithmetic model
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < LANES; i++) d[i*DW +: DW] = 8'($urandom);
      sc = int'($urandom_range(0, 200000));
      om = int'($urandom_range(0, 400000));
      md = b % 4;
      send(d, sc, om, md, ref_vec(d, sc, om, md));
    end
    idle();
    drain();

    // Reset with beats in flight
    data_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(lanes5(7 + i, 0, 0, 0, 0), 65536, 65536, 2, lanes5(7 + i, 0, 0, 0, 0));
    idle();
    n = 0;
    while (occupancy != 3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("occ_before_rst", occupancy, 3);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", data_out_valid, 0);
    chk("midrst_occupancy", occupancy, 0);
    chk("midrst_in_ready", data_in_ready, 1);
    data_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_stale_beat", data_out_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
